// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer for boot, redirect, stall and halt (optional perf counters via FETCH_PERF_CNT_EN)
module fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int BOOT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_src,
  output logic              pc_write_zero,
  output logic [ADDR_W-1:0] dest_pc,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              fetch_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       redirect_count
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic boot, in_run, br, hl, st, red, hlt;
  // decode the active request; reset overrides state so the reset cycle looks like BOOT
  always_comb begin
    boot   = reset || state == BOOT;
    in_run = !reset && state == RUN;
    red    = !reset && state == REDIRECT;
    hlt    = !reset && state == HALT;
    br     = in_run && branch_taken;
    hl     = in_run && !branch_taken && halt_req;
    st     = in_run && !branch_taken && !halt_req && stall_req;
  end
  // Mealy control outputs
  always_comb begin
    pc_src        = br;
    pc_write_zero = boot || hl || hlt || st;
    dest_pc       = branch_target;
    if_id_write   = !st;
    if_id_flush   = boot || br || red || hl || hlt;
    id_ex_flush   = boot || br || st;
    fetch_valid   = in_run && !br && !hl && !st;
    halted        = hlt;
  end
  // state and boot counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      cnt   <= 4'(BOOT_CYCLES - 1);
    end else begin
      if (state == BOOT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) state <= RUN;
      end
      if (br) state <= REDIRECT;
      else if (hl) state <= HALT;
      if (red) state <= RUN;
      if (hlt && resume) state <= REDIRECT;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  // saturating stall-cycle and accepted-redirect counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (st && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (br && redirect_count != '1) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch stage. Drives the PC hold, PC source select, branch target and IF/ID pipeline-register controls. Arbitrates between boot delay, branch redirect from EX, load-use stall from ID and halt/resume requests. Sits between the hazard and branch logic and the IF stage (PC register, PC+4 adder, PC mux, synchronous instruction memory).

Parameters:
ADDR_W, 16, PC / branch target width
BOOT_CYCLES, 2, cycles after reset release with PC held and fetch invalid (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
stall_req  input  1  load-use hazard from ID
branch_taken  input  1  taken branch/jump resolved in EX
branch_target  input  ADDR_W  redirect address from EX
halt_req  input  1  halt instruction decoded in ID
resume  input  1  leave HALT
pc_src  output  1  1 = PC mux selects dest_pc, 0 = pc_plus4
pc_write_zero  output  1  1 = PC holds current value
dest_pc  output  ADDR_W  target presented to PC mux
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID register clear (inserts NOP)
id_ex_flush  output  1  ID/EX register clear (bubble)
fetch_valid  output  1  instruction leaving IF this cycle is architecturally valid
halted  output  1  high in HALT

Behaviour:
- One clock, synchronous active-high reset. Reset at any time, including mid-stall or mid-HALT, forces BOOT and reloads the boot counter to BOOT_CYCLES-1.
- States: BOOT, RUN, REDIRECT, HALT. State and counter are registered. Outputs are combinational from state plus current inputs (Mealy); no additional latency.
- Defaults (RUN, no request): pc_src=0, pc_write_zero=0, dest_pc=branch_target, if_id_write=1, if_id_flush=0, id_ex_flush=0, fetch_valid=1, halted=0.
- During reset cycle and BOOT: pc_write_zero=1, if_id_write=1, if_id_flush=1, fetch_valid=0, pc_src=0, id_ex_flush=1. Counter decrements each cycle. Exit to RUN on the cycle the counter reads 0. BOOT lasts exactly BOOT_CYCLES cycles.
- Request priority in RUN: branch_taken > halt_req > stall_req.
- branch_taken (RUN): pc_src=1, pc_write_zero=0, if_id_flush=1, id_ex_flush=1, fetch_valid=0. PC loads branch_target on this edge. Next state is REDIRECT.
- REDIRECT (1 cycle): pc_src=0, if_id_flush=1, fetch_valid=0. This discards the word the synchronous memory read from the stale PC. Next state is RUN. A branch_taken in REDIRECT is ignored, since EX holds a bubble.
- halt_req (RUN, no branch): pc_write_zero=1, if_id_flush=1, fetch_valid=0. Next state is HALT.
- HALT: pc_write_zero=1, if_id_flush=1, id_ex_flush=0, halted=1, fetch_valid=0. stall_req, halt_req and branch_taken are ignored. resume leads to REDIRECT, which absorbs the stale memory word; the PC then resumes at the held value + 4.
- stall_req (RUN, no branch, no halt): pc_write_zero=1, if_id_write=0, id_ex_flush=1, fetch_valid=0. State stays RUN. Repeats each cycle while stall_req is held. There is no stall timeout.
- branch_taken together with stall_req or halt_req: the branch wins and the younger request is dropped, because it is wrong-path.
- pc_src and pc_write_zero are never both 1.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports stall_cycles[31:0] and redirect_count[31:0].
  - stall_cycles increments on every RUN cycle with stall applied.
  - redirect_count increments on every accepted branch_taken.
  - Both counters saturate at 32'hFFFFFFFF, clear on reset, and update on the registered edge.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Boot: reset high for 1 cycle then low, BOOT_CYCLES=2 -> pc_write_zero=1 and fetch_valid=0 for 2 cycles after release, then RUN with fetch_valid=1 and pc_write_zero=0.
2. Stall: stall_req high for 3 cycles in RUN -> pc_write_zero=1, if_id_write=0, id_ex_flush=1 for exactly 3 cycles, then defaults return the next cycle.
3. Redirect: branch_taken with branch_target=16'h0040 -> same cycle pc_src=1, dest_pc=16'h0040, if_id_flush=1. Next cycle REDIRECT with if_id_flush=1 and fetch_valid=0. Then RUN, with PC sequence 0x0040, 0x0044.
4. Priority: branch_taken, stall_req and halt_req all high in one cycle -> branch behaviour only, halted stays 0, pc_write_zero=0.
5. Halt/resume: halt_req at PC=0x0010 -> halted=1 and PC held at 0x0010 for 5 cycles. Pulse resume -> one REDIRECT cycle, then fetch_valid=1 with PC advancing to 0x0014.
6. Reset mid-stall: assert reset while stall_req is high -> next cycle BOOT, counter reloaded, stall_req ignored until RUN. With FETCH_PERF_CNT_EN defined, counters read 0.
